// File: rtl/cpu_pkg.sv
// Shared types for the hardwired controller and its beat/phase sequencer.
package cpu_pkg;
  typedef enum logic [1:0] {BEAT_W1 = 2'd0, BEAT_W2 = 2'd1, BEAT_W3 = 2'd2} beat_t;
  typedef enum logic [1:0] {PH_T1 = 2'd0, PH_T2 = 2'd1, PH_T3 = 2'd2} phase_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/qd_edge.sv
// Registers the debounced start button and flags its 0->1 transition.
module qd_edge (
  input  logic clk,
  input  logic clr,
  input  logic qd,
  output logic rise
);
  logic qd_d;

  always_ff @(posedge clk) begin
    if (!clr) qd_d <= 1'b0;
    else      qd_d <= qd;
  end

  // Combinational so an edge coinciding with the halting T3 edge is seen while still running.
  assign rise = qd & ~qd_d;
endmodule

// File: rtl/timing_gen.sv
// Beat (W1..W3) and phase (T1..T3) sequencer driving the hardwired controller.
module timing_gen
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic qd,
  input  logic dp,
  input  logic short,
  input  logic long,
  input  logic stop,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic t1,
  output logic t2,
  output logic t3,
  output logic running
);
  state_t state, state_n;
  beat_t  beat, beat_n, resume_beat, resume_n, nxt_beat;
  phase_t phase, phase_n;
  logic   start, halt;

  qd_edge u_qd_edge (.clk(clk), .clr(clr), .qd(qd), .rise(start));

  always_ff @(posedge clk) begin
    if (!clr) begin
      state       <= ST_IDLE;
      beat        <= BEAT_W1;
      phase       <= PH_T1;
      resume_beat <= BEAT_W1;
    end else begin
      state       <= state_n;
      beat        <= beat_n;
      phase       <= phase_n;
      resume_beat <= resume_n;
    end
  end

  // short only matters in W1, long only in W2
  always_comb begin
    nxt_beat = BEAT_W1;
    unique case (beat)
      BEAT_W1: nxt_beat = short ? BEAT_W1 : BEAT_W2;
      BEAT_W2: nxt_beat = long  ? BEAT_W3 : BEAT_W1;
      default: nxt_beat = BEAT_W1;
    endcase
  end

  assign halt = stop | (dp & (nxt_beat == BEAT_W1));

  always_comb begin
    state_n  = state;
    beat_n   = beat;
    phase_n  = phase;
    resume_n = resume_beat;
    unique case (state)
      ST_IDLE: if (start) begin
        state_n = ST_RUN;
        beat_n  = resume_beat;
        phase_n = PH_T1;
      end
      default: begin
        unique case (phase)
          PH_T1: phase_n = PH_T2;
          PH_T2: phase_n = PH_T3;
          default: begin
            phase_n = PH_T1;
            if (halt) begin
              state_n  = ST_IDLE;
              resume_n = nxt_beat;
            end else begin
              beat_n = nxt_beat;
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
    w1 = running & (beat == BEAT_W1);
    w2 = running & (beat == BEAT_W2);
    w3 = running & (beat == BEAT_W3);
    t1 = running & (phase == PH_T1);
    t2 = running & (phase == PH_T2);
    t3 = running & (phase == PH_T3);
  end
endmodule

// File: tb/tb_timing_gen.sv
// Scoreboard bench for timing_gen: a cycle model queues expected outputs each clock.
module tb_timing_gen;
  logic clk = 1'b0;
  logic clr, qd, dp, short, long, stop;
  logic w1, w2, w3, t1, t2, t3, running;

  timing_gen dut (
    .clk(clk), .clr(clr), .qd(qd), .dp(dp), .short(short), .long(long), .stop(stop),
    .w1(w1), .w2(w2), .w3(w3), .t1(t1), .t2(t2), .t3(t3), .running(running)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  string tag = "reset";
  logic [6:0] exp_q[$];

  // reference model state: beats/phases numbered 1..3
  bit m_run = 0;
  int m_beat = 1, m_ph = 1, m_res = 1;
  bit m_qdd = 0;
  int starts = 0;
  logic prev_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_out();
    if (!m_run) return 7'b0;
    return {1'b1, m_beat == 1, m_beat == 2, m_beat == 3, m_ph == 1, m_ph == 2, m_ph == 3};
  endfunction

  task automatic model_clock();
    int nb;
    if (!clr) begin
      m_run = 0; m_beat = 1; m_ph = 1; m_res = 1; m_qdd = 0;
      return;
    end
    if (!m_run) begin
      if (qd && !m_qdd) begin
        m_run = 1; m_beat = m_res; m_ph = 1;
      end
    end else if (m_ph < 3) begin
      m_ph++;
    end else begin
      if (m_beat == 1)      nb = short ? 1 : 2;
      else if (m_beat == 2) nb = long ? 3 : 1;
      else                  nb = 1;
      m_ph = 1;
      if (stop || (dp && nb == 1)) begin
        m_run = 0; m_res = nb;
      end else begin
        m_beat = nb;
      end
    end
    m_qdd = qd;
  endtask

  // one clock: predict, push, then compare after the edge
  task automatic step();
    logic [6:0] e;
    model_clock();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, {running, w1, w2, w3, t1, t2, t3}, e);
    if (running && !prev_run) starts++;
    prev_run = running;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_qd();
    qd = 1'b1; step();
    qd = 1'b0; step();
  endtask

  // advance until the current cycle is the given beat/phase while running
  task automatic wait_at(input int b, input int p);
    int k = 0;
    while (!(m_run && m_beat == b && m_ph == p) && k < 60) begin
      step(); k++;
    end
    chk({tag, "_timeout"}, {31'b0, m_run && m_beat == b && m_ph == p}, 32'd1);
  endtask

  initial begin
    clr = 1'b0; qd = 1'b0; dp = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;
    run(3);

    tag = "basic";
    clr = 1'b1;
    run(2);
    pulse_qd();
    run(14);

    tag = "long_w2";
    long = 1'b1;
    run(12);
    long = 1'b0;

    tag = "short_w1";
    wait_at(1, 3);
    short = 1'b1; step();
    short = 1'b0; run(3);

    tag = "short_stop";
    wait_at(1, 3);
    short = 1'b1; stop = 1'b1; step();
    short = 1'b0; stop = 1'b0; run(3);
    pulse_qd(); run(4);

    tag = "stop_w1";
    wait_at(1, 3);
    stop = 1'b1; step();
    stop = 1'b0; run(3);
    pulse_qd(); run(4);

    tag = "dp";
    dp = 1'b1;
    run(10);
    pulse_qd(); run(8);
    tag = "dp_long";
    long = 1'b1;
    pulse_qd(); run(12);
    dp = 1'b0; long = 1'b0;

    tag = "qd_at_halt";
    pulse_qd();
    wait_at(1, 3);
    stop = 1'b1; qd = 1'b1; step();
    stop = 1'b0; step();
    qd = 1'b0; run(3);

    tag = "reset_mid";
    pulse_qd();
    wait_at(2, 2);
    clr = 1'b0; step();
    clr = 1'b1; run(2);
    pulse_qd(); run(4);

    tag = "held_qd";
    wait_at(1, 3);
    stop = 1'b1; step();
    run(2);
    starts = 0;
    qd = 1'b1;
    run(10);
    chk("held_qd_starts", starts, 32'd1);
    qd = 1'b0; stop = 1'b0;
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
